// File: rtl/avalon_st_if.sv
// Avalon-ST source/sink bundle carrying framed packet beats (valid/ready, sop/eop, empty).
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned EMPTY_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic                  valid;
  logic                  sop;
  logic                  eop;
  logic [DATA_WIDTH-1:0] data;
  logic [EMPTY_W-1:0]    empty;
  logic                  ready;

  modport master (output valid, output sop, output eop, output data, output empty, input ready);
  modport slave  (input valid, input sop, input eop, input data, input empty, output ready);
endinterface

// File: rtl/avalon_packetizer.sv
// Frames a raw word stream into Avalon-ST packets of cfg_len bytes, with sop/eop/empty
// generated from a per-packet word counter and a single registered output stage.
module avalon_packetizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  cfg_ready,
  input  logic                  raw_valid,
  input  logic [DATA_WIDTH-1:0] raw_data,
  output logic                  raw_ready,
  avalon_st_if.master           packet_msg,
  output logic                  zero_len_error
);
  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned EMPTY_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned LW1     = LEN_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0]  total_words_q, total_words_d;
  logic [EMPTY_W-1:0]    last_empty_q, last_empty_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [EMPTY_W-1:0]    empty_q, empty_d;
  logic                  zero_len_error_q, zero_len_error_d;

  logic                  raw_xfer_c;
  logic                  last_word_c;
  logic [LEN_WIDTH-1:0]  len_rem_c;

  assign cfg_ready   = (state_q == IDLE);
  assign raw_ready   = (state_q == SEND) && (!valid_q || packet_msg.ready);
  assign raw_xfer_c  = raw_valid && raw_ready;
  assign last_word_c = (word_cnt_q == total_words_q - LEN_WIDTH'(1));
  assign len_rem_c   = cfg_len % LEN_WIDTH'(BYTES);

  assign packet_msg.valid = valid_q;
  assign packet_msg.sop   = sop_q;
  assign packet_msg.eop   = eop_q;
  assign packet_msg.data  = data_q;
  assign packet_msg.empty = empty_q;
  assign zero_len_error   = zero_len_error_q;

  // Next-state, counters and output-register load/clear.
  always_comb begin
    state_d          = state_q;
    word_cnt_d       = word_cnt_q;
    total_words_d    = total_words_q;
    last_empty_d     = last_empty_q;
    valid_d          = valid_q;
    sop_d            = sop_q;
    eop_d            = eop_q;
    data_d           = data_q;
    empty_d          = empty_q;
    zero_len_error_d = 1'b0;

    if (raw_xfer_c) begin
      valid_d = 1'b1;
      data_d  = raw_data;
      sop_d   = (word_cnt_q == '0);
      eop_d   = last_word_c;
      empty_d = last_word_c ? last_empty_q : '0;
    end else if (valid_q && packet_msg.ready) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      data_d  = '0;
      empty_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_len != '0) begin
            total_words_d = LEN_WIDTH'((LW1'(cfg_len) + LW1'(BYTES - 1)) / LW1'(BYTES));
            last_empty_d  = (len_rem_c == '0) ? '0 : EMPTY_W'(LEN_WIDTH'(BYTES) - len_rem_c);
            word_cnt_d    = '0;
            state_d       = SEND;
          end else begin
            zero_len_error_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (raw_xfer_c) begin
          word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
          if (last_word_c) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      word_cnt_q       <= '0;
      total_words_q    <= '0;
      last_empty_q     <= '0;
      valid_q          <= 1'b0;
      sop_q            <= 1'b0;
      eop_q            <= 1'b0;
      data_q           <= '0;
      empty_q          <= '0;
      zero_len_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      word_cnt_q       <= word_cnt_d;
      total_words_q    <= total_words_d;
      last_empty_q     <= last_empty_d;
      valid_q          <= valid_d;
      sop_q            <= sop_d;
      eop_q            <= eop_d;
      data_q           <= data_d;
      empty_q          <= empty_d;
      zero_len_error_q <= zero_len_error_d;
    end
  end
endmodule
